behav_sram_rw_scrub: RTL

Parametrised single-port behavioural SRAM for simulation memories: synchronous read and write through one port, configurable width, depth and write-mask granularity, and an optional output pipeline register. An in-built scrub state machine fills the array with a known value after reset or on request, and gates the port with a ready handshake while it runs. It replaces the fixed-size per-instance `*_ext` memory models in the subsystem and test-harness SRAM wrappers.

---
 rtl/behav_sram_pkg.sv | 32 +++
 rtl/behav_sram_array.sv | 63 ++++++
 rtl/behav_sram_rw_scrub.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/behav_sram_pkg.sv
// Shared types and elaboration helpers for the behavioural scrubbed SRAM.
// Holds the FSM state encoding plus the lane-count and parameter-legality functions.
package behav_sram_pkg;

    typedef enum logic {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } sram_state_e;

    function automatic int mask_lanes(input int data_width, input int mask_gran);
        return data_width / mask_gran;
    endfunction

    // Lane granularity must tile the word exactly and the array must fit the address space.
    function automatic bit params_legal(input int addr_width, input int depth,
                                        input int data_width, input int mask_gran);
        bit ok;
        ok = 1'b1;
        if (mask_gran <= 0 || data_width <= 0) begin
            ok = 1'b0;
        end else if ((data_width % mask_gran) != 0) begin
            ok = 1'b0;
        end
        if (depth < 1 || addr_width < 1 || addr_width > 31) begin
            ok = 1'b0;
        end else if (longint'(depth) > (longint'(1) << addr_width)) begin
            ok = 1'b0;
        end
        return ok;
    endfunction

endpackage

// File: rtl/behav_sram_array.sv
// Storage core: lane-masked synchronous write and a registered read data word.
// Addresses at or beyond DEPTH drop writes and read back OOR_VALUE.
module behav_sram_array
    import behav_sram_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 12,
    parameter int                    DEPTH      = 1 << ADDR_WIDTH,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    MASK_GRAN  = 8,
    parameter logic [DATA_WIDTH-1:0] OOR_VALUE  = '0
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic                                          we,
    input  logic                                          re,
    input  logic [ADDR_WIDTH-1:0]                         addr,
    input  logic [mask_lanes(DATA_WIDTH, MASK_GRAN)-1:0]  wmask,
    input  logic [DATA_WIDTH-1:0]                         wdata,
    output logic [DATA_WIDTH-1:0]                         rdata
);

    localparam int LANES = mask_lanes(DATA_WIDTH, MASK_GRAN);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH + 1)'(DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [DATA_WIDTH-1:0] rdata_d;
    logic                  in_range;
    logic [IDX_W-1:0]      idx;

    assign in_range = ({1'b0, addr} < DEPTH_C);
    assign idx      = addr[IDX_W-1:0];

    always_ff @(posedge clk) begin
        if (we && in_range) begin
            for (int i = 0; i < LANES; i++) begin
                if (wmask[i]) begin
                    mem_q[idx][i*MASK_GRAN +: MASK_GRAN] <= wdata[i*MASK_GRAN +: MASK_GRAN];
                end
            end
        end
    end

    // Read data only moves on a read, so later writes never disturb the held word.
    always_comb begin
        rdata_d = rdata_q;
        if (re) begin
            rdata_d = in_range ? mem_q[idx] : OOR_VALUE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/behav_sram_rw_scrub.sv
// Single-port behavioural SRAM with a scrub FSM that fills the array with INIT_VALUE
// after reset or on request, holding RW0_ready low while it runs.
module behav_sram_rw_scrub
    import behav_sram_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 12,
    parameter int                    DEPTH      = 1 << ADDR_WIDTH,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    MASK_GRAN  = 8,
    parameter int                    OUT_REG    = 0,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
    input  logic                                          RW0_clk,
    input  logic                                          RW0_reset,
    input  logic [ADDR_WIDTH-1:0]                         RW0_addr,
    input  logic                                          RW0_en,
    input  logic                                          RW0_wmode,
    input  logic [mask_lanes(DATA_WIDTH, MASK_GRAN)-1:0]  RW0_wmask,
    input  logic [DATA_WIDTH-1:0]                         RW0_wdata,
    input  logic                                          RW0_scrub,
    output logic                                          RW0_ready,
    output logic [DATA_WIDTH-1:0]                         RW0_rdata,
    output logic                                          RW0_rvalid
);

    localparam int LANES = mask_lanes(DATA_WIDTH, MASK_GRAN);
    localparam logic [ADDR_WIDTH-1:0] LAST_PTR = ADDR_WIDTH'(DEPTH - 1);

    if (!params_legal(ADDR_WIDTH, DEPTH, DATA_WIDTH, MASK_GRAN)) begin : g_bad_params
        $error("behav_sram_rw_scrub: illegal ADDR_WIDTH/DEPTH/DATA_WIDTH/MASK_GRAN combination");
    end

    sram_state_e           state_q, state_d;
    logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
    logic                  ready_q, ready_d;
    logic                  rvalid_q, rvalid_d;

    logic                  accept;
    logic                  arr_we;
    logic                  arr_re;
    logic [ADDR_WIDTH-1:0] arr_addr;
    logic [LANES-1:0]      arr_wmask;
    logic [DATA_WIDTH-1:0] arr_wdata;
    logic [DATA_WIDTH-1:0] arr_rdata;

    // Handshake: a request is taken on any rising edge where RW0_en and RW0_ready are both high;
    // RW0_ready is a registered copy of "FSM in ST_READY", so requests during a scrub are dropped.
    assign accept = RW0_en && ready_q;

    // Port mux: the scrub walker owns the array in ST_INIT, the external port otherwise.
    always_comb begin
        arr_we    = 1'b0;
        arr_re    = 1'b0;
        arr_addr  = RW0_addr;
        arr_wmask = RW0_wmask;
        arr_wdata = RW0_wdata;
        if (!RW0_reset) begin
            if (state_q == ST_INIT) begin
                arr_we    = 1'b1;
                arr_addr  = ptr_q;
                arr_wmask = '1;
                arr_wdata = INIT_VALUE;
            end else if (accept) begin
                arr_we = RW0_wmode;
                arr_re = !RW0_wmode;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        ready_d  = ready_q;
        rvalid_d = arr_re;
        case (state_q)
            ST_INIT: begin
                if (ptr_q == LAST_PTR) begin
                    state_d = ST_READY;
                    ptr_d   = '0;
                    ready_d = 1'b1;
                end else begin
                    ptr_d = ptr_q + 1'b1;
                end
            end
            ST_READY: begin
                // Any request accepted alongside the scrub has already been routed above.
                if (RW0_scrub) begin
                    state_d = ST_INIT;
                    ptr_d   = '0;
                    ready_d = 1'b0;
                end
            end
            default: begin
                state_d = ST_INIT;
                ptr_d   = '0;
                ready_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge RW0_clk) begin
        if (RW0_reset) begin
            state_q  <= ST_INIT;
            ptr_q    <= '0;
            ready_q  <= 1'b0;
            rvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            ready_q  <= ready_d;
            rvalid_q <= rvalid_d;
        end
    end

    behav_sram_array #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH      (DEPTH),
        .DATA_WIDTH (DATA_WIDTH),
        .MASK_GRAN  (MASK_GRAN),
        .OOR_VALUE  (INIT_VALUE)
    ) u_array (
        .clk   (RW0_clk),
        .rst   (RW0_reset),
        .we    (arr_we),
        .re    (arr_re),
        .addr  (arr_addr),
        .wmask (arr_wmask),
        .wdata (arr_wdata),
        .rdata (arr_rdata)
    );

    if (OUT_REG != 0) begin : g_out_reg
        logic [DATA_WIDTH-1:0] out_rdata_q, out_rdata_d;
        logic                  out_rvalid_q, out_rvalid_d;

        // The stage only reloads on a fresh read so held data survives intervening writes.
        always_comb begin
            out_rvalid_d = rvalid_q;
            out_rdata_d  = rvalid_q ? arr_rdata : out_rdata_q;
        end

        always_ff @(posedge RW0_clk) begin
            if (RW0_reset) begin
                out_rdata_q  <= '0;
                out_rvalid_q <= 1'b0;
            end else begin
                out_rdata_q  <= out_rdata_d;
                out_rvalid_q <= out_rvalid_d;
            end
        end

        assign RW0_rdata  = out_rdata_q;
        assign RW0_rvalid = out_rvalid_q;
    end else begin : g_no_out_reg
        assign RW0_rdata  = arr_rdata;
        assign RW0_rvalid = rvalid_q;
    end

    assign RW0_ready = ready_q;

endmodule
